// File: rtl/hanoi_pkg.sv
// Shared types for the linear (adjacent-only) Tower of Hanoi move sequencer.
package hanoi_pkg;

    typedef logic [1:0] rod_t;

    // Rod encoding parked on from_rod/to_rod when no move is offered.
    localparam rod_t IDLE_ROD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Travel direction of a disk along the line of rods.
    typedef enum logic {
        DIR_UP   = 1'b0,   // towards rod 2
        DIR_DOWN = 1'b1    // towards rod 0
    } dir_t;

    // Neighbouring rod in the given direction.
    function automatic rod_t step_rod(rod_t r, dir_t d);
        return (d == DIR_UP) ? rod_t'(r + 2'd1) : rod_t'(r - 2'd1);
    endfunction

endpackage

// File: rtl/hanoi_ternary_counter.sv
// N-digit ternary counter. Each increment bumps the lowest digit that is not
// yet 2 and clears the 2s below it; that digit index names the disk to move.
module hanoi_ternary_counter #(
    parameter  int N     = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [IDX_W-1:0] lowest,
    output logic             all_twos
);

    logic [1:0] digit [N];

    // Locate the lowest digit that can still be incremented.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        lowest   = '0;
        all_twos = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (digit[i] != 2'd2) begin
                lowest   = IDX_W'(i);
                all_twos = 1'b0;
            end
        end
    end

    // Digit update: clear on reset/restart, otherwise reflected increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < N; i++) digit[i] <= 2'd0;
        end else if (inc && !all_twos) begin
            for (int i = 0; i < N; i++) begin
                if (IDX_W'(i) < lowest)       digit[i] <= 2'd0;
                else if (IDX_W'(i) == lowest) digit[i] <= digit[i] + 2'd1;
            end
        end
    end

endmodule

// File: rtl/hanoi_move_sequencer.sv
// Offers the 3^N-1 adjacent-only moves that carry N disks from rod 0 to rod 2,
// one move per accepted valid/ready handshake.
module hanoi_move_sequencer
    import hanoi_pkg::*;
#(
    parameter  int NUMBER_OF_DISKS = 3,
    parameter  int NUMBER_OF_RODS  = 3,
    localparam int RODS_LOG2       = $clog2(NUMBER_OF_RODS),
    localparam int DISKS_LOG2      = $clog2(NUMBER_OF_DISKS + 1),
    localparam int TOTAL_MOVES     = 3 ** NUMBER_OF_DISKS - 1,
    localparam int MOVE_W          = $clog2(TOTAL_MOVES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  move_ready,
    output logic                  move_valid,
    output logic [RODS_LOG2-1:0]  from_rod,
    output logic [RODS_LOG2-1:0]  to_rod,
    output logic [DISKS_LOG2-1:0] disk_id,
    output logic [MOVE_W-1:0]     move_count,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = (NUMBER_OF_DISKS > 1) ? $clog2(NUMBER_OF_DISKS) : 1;

    if (NUMBER_OF_RODS != 3) begin : g_bad_rods
        $error("hanoi_move_sequencer: the linear solution needs exactly 3 rods");
    end
    if (NUMBER_OF_DISKS < 1 || NUMBER_OF_DISKS > 8) begin : g_bad_disks
        $error("hanoi_move_sequencer: NUMBER_OF_DISKS must be 1..8");
    end

    seq_state_e        state, state_next;
    rod_t              pos [NUMBER_OF_DISKS];
    dir_t              dir [NUMBER_OF_DISKS];
    logic [IDX_W-1:0]  sel;
    logic              all_twos;
    rod_t              cur_pos, nxt_pos;
    dir_t              cur_dir;
    logic              init, accept, last;

    hanoi_ternary_counter #(.N(NUMBER_OF_DISKS)) u_tern (
        .clk      (clk),
        .rst      (rst),
        .inc      (accept),
        .clr      (init),
        .lowest   (sel),
        .all_twos (all_twos)
    );

    // Position and direction of the disk chosen by the ternary counter.
    always_comb begin
        cur_pos = '0;
        cur_dir = DIR_UP;
        for (int d = 0; d < NUMBER_OF_DISKS; d++) begin
            if (IDX_W'(d) == sel) begin
                cur_pos = pos[d];
                cur_dir = dir[d];
            end
        end
        nxt_pos = step_rod(cur_pos, cur_dir);
    end

    assign accept = move_valid && move_ready;
    assign last   = (move_count == MOVE_W'(TOTAL_MOVES - 1));

    // FSM next state and all outputs; outputs depend on registered state only.
    always_comb begin
        state_next = state;
        init       = 1'b0;
        move_valid = 1'b0;
        from_rod   = IDLE_ROD;
        to_rod     = IDLE_ROD;
        disk_id    = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    init       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                move_valid = 1'b1;
                busy       = 1'b1;
                from_rod   = cur_pos;
                to_rod     = nxt_pos;
                disk_id    = DISKS_LOG2'(sel) + DISKS_LOG2'(1);
                // all_twos only guards against a counter that has run out early.
                if ((move_ready && last) || all_twos) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    init       = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Disk positions, directions and accepted-move count.
    always_ff @(posedge clk) begin
        if (rst || init) begin
            // NOTE: pos/dir are reset too, so they never carry X into a run.
            for (int d = 0; d < NUMBER_OF_DISKS; d++) begin
                pos[d] <= 2'd0;
                dir[d] <= DIR_UP;
            end
            move_count <= '0;
        end else if (accept) begin
            for (int d = 0; d < NUMBER_OF_DISKS; d++) begin
                if (IDX_W'(d) == sel) begin
                    pos[d] <= nxt_pos;
                    // A disk bounces off the end rods.
                    if (nxt_pos == 2'd0 || nxt_pos == 2'd2)
                        dir[d] <= (dir[d] == DIR_UP) ? DIR_DOWN : DIR_UP;
                end
            end
            move_count <= move_count + MOVE_W'(1);
        end
    end

endmodule

// File: doc/hanoi_move_sequencer.md
Name: hanoi_move_sequencer

Overview:
- Command generator directly upstream of move_disk. Drives move_disk's from_rod/to_rod ports with the optimal adjacent-only solution: all disks go from rod 0 to rod 2, and no move is ever 0<->2.
- The sequence is the 3^N-1-move reflected-ternary-Gray-code solution of linear Hanoi. Output is one move per accepted handshake.
- When no move is offered, the block parks from_rod/to_rod on an out-of-range encoding so that move_disk ignores the cycle.

Parameters:
- NUMBER_OF_DISKS, 3, disk count N (1..8).
- NUMBER_OF_RODS, 3, fixed at 3; the algorithm is defined for three rods in a line only. Elaboration error if not 3.
- RODS_LOG2, $clog2(NUMBER_OF_RODS), localparam, rod index width (2).
- DISKS_LOG2, $clog2(NUMBER_OF_DISKS+1), localparam, disk id width.
- TOTAL_MOVES, 3**NUMBER_OF_DISKS-1, localparam.
- MOVE_W, $clog2(TOTAL_MOVES+1), localparam, width of move_count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a solution run.
- move_ready  in  1  consumer accepts the offered move this cycle.
- move_valid  out  1  a move is offered.
- from_rod  out  RODS_LOG2  source rod; equals IDLE_ROD (3) when move_valid=0.
- to_rod  out  RODS_LOG2  destination rod; equals IDLE_ROD (3) when move_valid=0.
- disk_id  out  DISKS_LOG2  disk being moved (1 = smallest); 0 when move_valid=0.
- move_count  out  MOVE_W  number of moves accepted in the current run.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, move_valid=0, from_rod=to_rod=IDLE_ROD, disk_id=0, move_count=0, busy=0, done=0.
- Reset mid-run: the block returns to IDLE on the next edge and drops any offered move.
- State registers:
  - pos[d]: current rod of each disk, 2 bits per disk.
  - dir[d]: direction of each disk (+1 / -1).
  - tern[d]: ternary digit counter, N digits, each 0..2.
  - move_count.
  - FSM state.
- FSM IDLE:
  - On start: set pos[*]=0, dir[*]=+1, tern=0, move_count=0; go to RUN.
  - Otherwise stay in IDLE.
- FSM RUN:
  - move_valid=1.
  - Disk selection: d = lowest index with tern[d]!=2 (index 0 = disk 1). disk_id=d+1.
  - Move offered: from_rod=pos[d], to_rod=pos[d]+dir[d].
  - On move_valid && move_ready:
    - pos[d] <= to_rod.
    - If to_rod is 0 or 2, dir[d] flips.
    - tern[d] increments; all lower digits (which were 2) clear to 0.
    - move_count increments.
  - If this was move number TOTAL_MOVES, go to DONE on the same edge.
- FSM DONE:
  - done=1, move_valid=0.
  - start re-enters RUN with state re-initialised. The integrator must reset move_disk alongside the restart.
- Start handling: start in RUN is ignored. start in the same cycle as rst is ignored (reset wins).
- Outputs are combinational functions of registered state only; there is no input-to-output path.
- Latency: start sampled at edge t gives move_valid=1 after edge t. The last handshake at edge t' gives done=1 after t'.
- Throughput: one move per cycle when move_ready is held at 1; there are no bubbles between moves.
- Backpressure: while move_valid && !move_ready, every output holds stable.
- Invariants:
  - No move is 0->2 or 2->0.
  - to_rod is always 0..2 when valid.
  - Every offered move is legal: the moved disk is on top of from_rod and smaller than the top of to_rod.
- End condition: at done, pos[*]=2 for all disks and move_count=TOTAL_MOVES.

Decomposition:
- hanoi_pkg holds:
  - rod_t (logic [1:0]).
  - IDLE_ROD=2'd3.
  - seq_state_e {IDLE, RUN, DONE}.
  - A dir_t encoding.
- Sub-module hanoi_ternary_counter (parameter N):
  - Inputs: inc, clr.
  - Outputs: digit index of the lowest non-2 digit, and all_twos.
  - The sequencer keeps pos, dir, FSM and handshake logic.

Test Plan:
- Reset: apply rst for 2 cycles -> move_valid=0, from_rod=to_rod=3, disk_id=0, move_count=0, done=0, busy=0.
- Full run, N=3, move_ready=1, start pulse at t -> moves accepted t+1..t+26 in order:
  - Moves 1..4: (1:0->1), (1:1->2), (2:0->1), (1:2->1).
  - Moves 26 and later: last move is (1:1->2).
  - done=1 at t+27, move_count=26.
- Full run, N=3, random move_ready: identical 26-move sequence; outputs are stable on every stalled cycle. A scoreboard reference model of the three rods checks every move is legal, never 0<->2, and all disks end on rod 2.
- start pulsed during RUN at move 10 -> ignored; sequence and count unaffected.
- rst asserted at move 13 -> IDLE next edge with outputs at reset values. A subsequent start replays from move 1.
- N=1 -> exactly 2 moves, (1:0->1) then (1:1->2), then done. Restart from DONE by pulsing start repeats the 2-move sequence.
